// File: rtl/dc_removal.sv
// Streaming DC-offset canceller: subtracts a 2^LOG2_N-sample moving-average estimate from each input sample.
// Optional build macro DC_REMOVAL_ROUND_EN selects round-half-up instead of floor for the estimate.
module dc_removal #(
    parameter int DW     = 32,
    parameter int LOG2_N = 4
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    input  logic          clr,
    output logic          dout_valid,
    output logic [DW-1:0] dout,
    output logic [DW-1:0] dc_est,
    output logic          settled
);

    localparam int N  = 1 << LOG2_N;
    localparam int AW = DW + LOG2_N;
    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] N_CNT = CW'(N);

`ifdef DC_REMOVAL_ROUND_EN
    localparam logic signed [AW-1:0] HALF = AW'(1) << (LOG2_N - 1);
`endif

    // Window average; the accumulator holds a sum of at most N DW-bit values, so AW bits never overflow.
    function automatic logic signed [DW-1:0] dc_shift(input logic signed [AW-1:0] a);
`ifdef DC_REMOVAL_ROUND_EN
        return DW'((a + HALF) >>> LOG2_N);
`else
        return DW'(a >>> LOG2_N);
`endif
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW:0] v);
        if (v[DW] != v[DW-1])
            return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            return v[DW-1:0];
    endfunction

    logic signed [DW-1:0] sample_mem [N];
    logic signed [AW-1:0] acc;
    logic [LOG2_N-1:0]    wr_ptr;
    logic [CW-1:0]        cnt;

    logic signed [DW-1:0] din_s;
    logic                 accept_p0;
    logic                 full_p0;
    logic signed [DW-1:0] old_p0;
    logic signed [AW-1:0] acc_next_p0;
    logic signed [DW-1:0] est_p0;
    logic signed [DW:0]   diff_p0;
    logic signed [DW-1:0] dout_p0;
    logic [CW-1:0]        cnt_next_p0;

    logic                 vld_p1;
    logic                 settled_p1;
    logic signed [DW-1:0] dout_p1;
    logic signed [DW-1:0] dc_est_p1;

    // Stage p0: window update and output computation for the incoming sample
    always_comb begin
        din_s       = $signed(din);
        accept_p0   = din_valid & ~clr;
        full_p0     = (cnt == N_CNT);
        old_p0      = full_p0 ? sample_mem[wr_ptr] : '0;
        acc_next_p0 = acc + AW'(din_s) - AW'(old_p0);
        est_p0      = dc_shift(acc_next_p0);
        diff_p0     = (DW+1)'(din_s) - (DW+1)'(est_p0);
        dout_p0     = sat_dw(diff_p0);
        cnt_next_p0 = cnt;
        if (clr)
            cnt_next_p0 = '0;
        else if (accept_p0 && !full_p0)
            cnt_next_p0 = cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (accept_p0)
            sample_mem[wr_ptr] <= din_s;
    end

    // Stage p1: registered outputs, one cycle after an accepted sample
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            acc        <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            vld_p1     <= 1'b0;
            settled_p1 <= 1'b0;
            dout_p1    <= '0;
            dc_est_p1  <= '0;
        end else begin
            vld_p1     <= accept_p0;
            settled_p1 <= (cnt_next_p0 == N_CNT);
            cnt        <= cnt_next_p0;
            if (clr) begin
                acc    <= '0;
                wr_ptr <= '0;
            end else if (accept_p0) begin
                acc    <= acc_next_p0;
                wr_ptr <= wr_ptr + LOG2_N'(1);
            end
            if (accept_p0) begin
                dout_p1   <= dout_p0;
                dc_est_p1 <= est_p0;
            end
        end
    end

    assign dout_valid = vld_p1;
    assign settled    = settled_p1;
    assign dout       = dout_p1;
    assign dc_est     = dc_est_p1;

endmodule
